// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-channel multiplexer.
// Mode encodings and a lowest-set-bit helper.
package mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_PRIO   = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  localparam int MAX_CH = 32;

  function automatic int lowest_set(
    input logic [MAX_CH-1:0] v
  );
    int r;
    r = 0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_reg_arbiter.sv
// Combinational grant logic: manual select, fixed priority
// or round-robin from a pointer. Grant is one-hot or zero.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic [1:0]      mode,
  input  logic [CH_W-1:0] sel,
  output logic [N_CH-1:0] grant
);

  logic [N_CH-1:0] g_man;
  logic [N_CH-1:0] g_pri;
  logic [N_CH-1:0] g_rr;

  always_comb begin
    g_man = '0;
    if (int'(sel) < N_CH) begin
      if (req[sel]) g_man[sel] = 1'b1;
    end
  end

  always_comb begin
    g_pri = '0;
    if (|req) g_pri[lowest_set(MAX_CH'(req))] = 1'b1;
  end

  // Search starts at ptr and wraps once around all channels.
  always_comb begin
    int  idx;
    logic found;
    g_rr  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && req[idx]) begin
        g_rr[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    unique case (1'b1)
      mode == MODE_MANUAL: grant = g_man;
      mode == MODE_PRIO:   grant = g_pri;
      mode == MODE_RR:     grant = g_rr;
      default:             grant = '0;
    endcase
  end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-channel mux with per-channel valid/ready and a
// one-entry output register; owns the round-robin pointer.
module mux_rr_reg
  import mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int CH_W  = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic [CH_W-1:0]         sel,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]         out_ch
);

  typedef struct packed {
    logic             valid;
    logic [CH_W-1:0]  ch;
    logic [WIDTH-1:0] data;
  } oreg_t;

  oreg_t           oreg;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] gidx;
  logic [CH_W-1:0] ptr_nxt;
  logic [N_CH-1:0] grant;
  logic            load_en;
  logic            xfer;

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .mode  (mode),
    .sel   (sel),
    .grant (grant)
  );

  assign load_en  = !oreg.valid || out_ready;
  assign in_ready = rst ? '0 : (grant & {N_CH{load_en}});
  assign xfer     = |(in_valid & in_ready);
  assign gidx     = CH_W'(lowest_set(MAX_CH'(grant)));
  assign ptr_nxt  = (int'(gidx) == N_CH - 1) ? '0
                  : gidx + 1'b1;

  // A load wins over a drain, giving one word per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      oreg   <= '0;
      rr_ptr <= '0;
    end else begin
      if (xfer) begin
        oreg.valid <= 1'b1;
        oreg.ch    <= gidx;
        oreg.data  <= in_data[gidx*WIDTH +: WIDTH];
        if (mode == MODE_RR) rr_ptr <= ptr_nxt;
      end else if (oreg.valid && out_ready) begin
        oreg.valid <= 1'b0;
      end
    end
  end

  assign out_valid = oreg.valid;
  assign out_data  = oreg.data;
  assign out_ch    = oreg.ch;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed scenarios plus random traffic
// compared every cycle against a behavioural model.
module tb_mux_rr_reg;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [CW-1:0] sel;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_ch;

  int checks   = 0;
  int failures = 0;

  bit m_v   = 1'b0;
  int m_d   = 0;
  int m_ch  = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  mux_rr_reg #(.N_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    case (mode)
      2'd0: if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      2'd1: for (int i = N - 1; i >= 0; i--)
              if (in_valid[i]) g = i;
      2'd2: for (int k = N - 1; k >= 0; k--)
              if (in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      default: g = -1;
    endcase
    return g;
  endfunction

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    int          g;
    bit          le;
    logic [N-1:0] er;
    #1;
    g  = model_grant();
    le = !m_v || out_ready;
    er = '0;
    if (!rst && g >= 0 && le) er[g] = 1'b1;
    chk("m_in_ready", 32'(in_ready), 32'(er));
    chk("m_out_valid", 32'(out_valid), 32'(m_v));
    chk("m_out_data", 32'(out_data), m_d);
    chk("m_out_ch", 32'(out_ch), m_ch);
    @(posedge clk);
    if (rst) begin
      m_v = 0; m_d = 0; m_ch = 0; m_ptr = 0;
    end else if (er != '0) begin
      m_v  = 1;
      m_d  = int'(in_data[g*W +: W]);
      m_ch = g;
      if (mode == 2'd2) m_ptr = (g + 1) % N;
    end else if (m_v && out_ready) begin
      m_v = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    int exp_seq [5];
    exp_seq = '{1, 2, 3, 0, 1};
    rst       = 1'b1;
    mode      = 2'b10;
    sel       = '0;
    in_valid  = 4'b1111;
    in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    out_ready = 1'b1;
    @(negedge clk);

    tick();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);

    rst = 1'b0;
    #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    tick();
    chk("rr_first_valid", 32'(out_valid), 32'h1);
    chk("rr_first_ch", 32'(out_ch), 32'h0);
    chk("rr_first_data", 32'(out_data), 32'hA0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq_ch", 32'(out_ch), 32'(exp_seq[i]));
    end

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      tick();
      chk("bp_out_ch", 32'(out_ch), 32'h1);
      chk("bp_out_data", 32'(out_data), 32'hB1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'h4);
    tick();
    chk("bp_resume_ch", 32'(out_ch), 32'h2);
    chk("bp_resume_valid", 32'(out_valid), 32'h1);

    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_ch", 32'(out_ch), 32'h0);

    mode     = 2'b01;
    in_valid = 4'b1010;
    tick();
    chk("prio_ch", 32'(out_ch), 32'h1);
    chk("prio_data", 32'(out_data), 32'hB1);
    tick();
    chk("prio_ch2", 32'(out_ch), 32'h1);

    mode     = 2'b10;
    in_valid = 4'b1111;
    #1;
    chk("rr_retained_ready", 32'(in_ready), 32'h2);
    tick();
    chk("rr_retained_ch", 32'(out_ch), 32'h1);
    tick();
    chk("rr_retained_next", 32'(out_ch), 32'h2);

    mode = 2'b00;
    sel  = 2'd2;
    #1;
    chk("man_ready", 32'(in_ready), 32'h4);
    tick();
    chk("man_data", 32'(out_data), 32'hC2);
    chk("man_ch", 32'(out_ch), 32'h2);
    in_valid = 4'b1011;
    #1;
    chk("man_novalid_ready", 32'(in_ready), 32'h0);
    tick();
    chk("man_novalid_out", 32'(out_valid), 32'h0);

    mode     = 2'b11;
    in_valid = 4'b1111;
    #1;
    chk("rsvd_ready", 32'(in_ready), 32'h0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      mode      = 2'($urandom_range(0, 3));
      sel       = CW'($urandom_range(0, N - 1));
      in_valid  = N'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
